// File: rtl/mem_stage.sv
// SPU memory stage: consumes EX/MEM, runs quadword local-store accesses over a
// req/ack handshake, resolves branches and drives the registered MEM/WB outputs.
module mem_stage #(
    parameter int LS_ADDR_W = 14
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 exm_valid,
    input  logic                 exm_is_load,
    input  logic                 exm_is_store,
    input  logic                 exm_is_branch,
    input  logic                 exm_reg_write,
    input  logic [31:0]          exm_jump_pc,
    input  logic                 exm_zero,
    input  logic [127:0]         exm_alu_result,
    input  logic [127:0]         exm_store_data,
    input  logic [6:0]           exm_rt,
    output logic                 mem_stall,
    output logic                 ls_req,
    output logic                 ls_we,
    output logic [LS_ADDR_W-1:0] ls_addr,
    output logic [127:0]         ls_wdata,
    input  logic                 ls_ack,
    input  logic [127:0]         ls_rdata,
    output logic                 branch_taken,
    output logic [31:0]          branch_target,
    output logic                 wb_valid,
    output logic                 wb_reg_write,
    output logic [6:0]           wb_rt,
    output logic [127:0]         wb_data,
    output logic [31:0]          stall_cnt
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t                 state_r;
    logic                   ls_req_r;
    logic                   ls_we_r;
    logic [LS_ADDR_W-1:0]   ls_addr_r;
    logic [127:0]           ls_wdata_r;
    logic                   branch_taken_r;
    logic [31:0]            branch_target_r;
    logic                   wb_valid_r;
    logic                   wb_reg_write_r;
    logic [6:0]             wb_rt_r;
    logic [127:0]           wb_data_r;
    logic [31:0]            stall_cnt_r;

    logic                   mem_op_s;
    logic                   mem_stall_s;
    logic                   is_load_s;
    logic                   br_hit_s;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) begin
            return v;
        end else begin
            return v + 32'd1;
        end
    endfunction

    // Decode of the held EX/MEM instruction; a load+store combination acts as a store.
    always_comb begin
        mem_op_s  = exm_valid & (exm_is_load | exm_is_store);
        is_load_s = exm_valid & exm_is_load & ~exm_is_store;
        br_hit_s  = exm_valid & exm_is_branch & exm_zero;
    end

    // Stall: new memory op in IDLE, or outstanding access without ack; quiet during reset.
    always_comb begin
        mem_stall_s = 1'b0;
        if (reset) begin
            mem_stall_s = 1'b0;
        end else begin
            case (state_r)
                IDLE:    mem_stall_s = mem_op_s;
                REQ:     mem_stall_s = ~ls_ack;
                default: mem_stall_s = 1'b0;
            endcase
        end
    end

    // Access FSM with registered local-store request signals.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            ls_req_r   <= 1'b0;
            ls_we_r    <= 1'b0;
            ls_addr_r  <= {LS_ADDR_W{1'b0}};
            ls_wdata_r <= 128'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (mem_op_s) begin
                        ls_addr_r  <= exm_alu_result[100 +: LS_ADDR_W];
                        ls_we_r    <= exm_is_store;
                        ls_wdata_r <= exm_store_data;
                        ls_req_r   <= 1'b1;
                        state_r    <= REQ;
                    end else begin
                        ls_req_r   <= 1'b0;
                    end
                end
                REQ: begin
                    if (ls_ack) begin
                        ls_req_r <= 1'b0;
                        state_r  <= IDLE;
                    end else begin
                        ls_req_r <= 1'b1;
                    end
                end
                default: begin
                    ls_req_r <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

    // MEM/WB register and branch pulse; a stalled edge inserts a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid_r      <= 1'b0;
            wb_reg_write_r  <= 1'b0;
            wb_rt_r         <= 7'd0;
            wb_data_r       <= 128'd0;
            branch_taken_r  <= 1'b0;
            branch_target_r <= 32'd0;
        end else if (mem_stall_s) begin
            wb_valid_r      <= 1'b0;
            wb_reg_write_r  <= 1'b0;
            branch_taken_r  <= 1'b0;
        end else begin
            wb_valid_r      <= exm_valid;
            wb_reg_write_r  <= exm_valid & exm_reg_write & ~exm_is_store;
            wb_rt_r         <= exm_rt;
            wb_data_r       <= is_load_s ? ls_rdata : exm_alu_result;
            branch_taken_r  <= br_hit_s;
            if (br_hit_s) begin
                branch_target_r <= exm_jump_pc;
            end else begin
                branch_target_r <= branch_target_r;
            end
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_r <= 32'd0;
        end else if (mem_stall_s) begin
            stall_cnt_r <= sat_inc(stall_cnt_r);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign mem_stall     = mem_stall_s;
    assign ls_req        = ls_req_r;
    assign ls_we         = ls_we_r;
    assign ls_addr       = ls_addr_r;
    assign ls_wdata      = ls_wdata_r;
    assign branch_taken  = branch_taken_r;
    assign branch_target = branch_target_r;
    assign wb_valid      = wb_valid_r;
    assign wb_reg_write  = wb_reg_write_r;
    assign wb_rt         = wb_rt_r;
    assign wb_data       = wb_data_r;
    assign stall_cnt     = stall_cnt_r;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: a transaction-level model predicts address,
// occupancy, MEM/WB contents, branch pulses and the stall counter.
module tb_mem_stage;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          reset;
    logic          exm_valid, exm_is_load, exm_is_store, exm_is_branch, exm_reg_write;
    logic [31:0]   exm_jump_pc;
    logic          exm_zero;
    logic [127:0]  exm_alu_result, exm_store_data;
    logic [6:0]    exm_rt;
    logic          mem_stall, ls_req, ls_we;
    logic [AW-1:0] ls_addr;
    logic [127:0]  ls_wdata;
    logic          ls_ack;
    logic [127:0]  ls_rdata;
    logic          branch_taken;
    logic [31:0]   branch_target;
    logic          wb_valid, wb_reg_write;
    logic [6:0]    wb_rt;
    logic [127:0]  wb_data;
    logic [31:0]   stall_cnt;

    int            n_vec = 0;
    int            n_err = 0;
    logic [127:0]  ls_mem  [0:(1<<AW)-1];
    logic [127:0]  ref_mem [0:(1<<AW)-1];
    longint        exp_stall = 0;

    mem_stage #(.LS_ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .exm_valid(exm_valid), .exm_is_load(exm_is_load), .exm_is_store(exm_is_store),
        .exm_is_branch(exm_is_branch), .exm_reg_write(exm_reg_write),
        .exm_jump_pc(exm_jump_pc), .exm_zero(exm_zero),
        .exm_alu_result(exm_alu_result), .exm_store_data(exm_store_data), .exm_rt(exm_rt),
        .mem_stall(mem_stall), .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_ack(ls_ack), .ls_rdata(ls_rdata),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rt(wb_rt),
        .wb_data(wb_data), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive_idle();
        exm_valid = 1'b0; exm_is_load = 1'b0; exm_is_store = 1'b0; exm_is_branch = 1'b0;
        exm_reg_write = 1'b0; exm_zero = 1'b0; exm_jump_pc = 32'd0;
        exm_alu_result = 128'd0; exm_store_data = 128'd0; exm_rt = 7'd0;
    endtask

    // One instruction through MEM; called right after a falling edge. d = ack delay after ls_req rises.
    task automatic run_op(input logic v, input logic ld, input logic st, input logic br,
                          input logic rw, input logic zr, input logic [31:0] jpc,
                          input logic [127:0] alu, input logic [127:0] sd,
                          input logic [6:0] rt, input int d);
        logic         mop;
        int           ea;
        logic [127:0] exp_data;
        exm_valid = v; exm_is_load = ld; exm_is_store = st; exm_is_branch = br;
        exm_reg_write = rw; exm_zero = zr; exm_jump_pc = jpc;
        exm_alu_result = alu; exm_store_data = sd; exm_rt = rt;
        mop = v & (ld | st);
        #1;
        check_eq("stall_accept", mem_stall, mop);
        exp_data = alu;
        if (mop) begin
            ea = int'(alu[127:96] / 32'd16) % (1 << AW);
            exp_stall = exp_stall + d + 1;
            @(posedge clk); @(negedge clk);
            check_eq("req_rise", ls_req, 1'b1);
            check_eq("ls_addr", ls_addr, ea);
            check_eq("ls_we", ls_we, st);
            if (st) check_eq("ls_wdata", ls_wdata, sd);
            check_eq("bubble", wb_valid, 1'b0);
            for (int i = 0; i < d; i++) begin
                ls_ack = 1'b0;
                #1;
                check_eq("stall_wait", mem_stall, 1'b1);
                @(posedge clk); @(negedge clk);
                check_eq("req_hold", ls_req, 1'b1);
            end
            ls_ack = 1'b1;
            ls_rdata = ls_we ? rand128() : ls_mem[ls_addr];
            if (ls_we) ls_mem[ls_addr] = ls_wdata;
            #1;
            check_eq("stall_ack", mem_stall, 1'b0);
            if (st) ref_mem[ea] = sd;
            else exp_data = ref_mem[ea];
            @(posedge clk); @(negedge clk);
            ls_ack = 1'b0;
            check_eq("req_fall", ls_req, 1'b0);
        end else begin
            @(posedge clk); @(negedge clk);
        end
        if (exp_stall > 64'hFFFF_FFFF) exp_stall = 64'hFFFF_FFFF;
        check_eq("wb_valid", wb_valid, v);
        check_eq("wb_reg_write", wb_reg_write, v & rw & ~st);
        check_eq("wb_rt", wb_rt, rt);
        check_eq("wb_data", wb_data, exp_data);
        check_eq("br_taken", branch_taken, v & br & zr);
        if (v & br & zr) check_eq("br_target", branch_target, jpc);
        check_eq("stall_cnt", stall_cnt, exp_stall[31:0]);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ls_mem[i]  = rand128();
            ref_mem[i] = ls_mem[i];
        end
        drive_idle();
        ls_ack = 1'b0; ls_rdata = 128'd0;
        reset = 1'b1;
        #1;
        check_eq("rst_req", ls_req, 1'b0);
        check_eq("rst_wb_valid", wb_valid, 1'b0);
        check_eq("rst_stall_cnt", stall_cnt, 32'd0);
        check_eq("rst_br", branch_taken, 1'b0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // directed: passthrough, load, store, branches
        run_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0,
               128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978, 128'd0, 7'd5, 0);
        run_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0,
               {32'h0000_0120, 96'd7}, 128'd0, 7'd9, 2);
        run_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0,
               {32'h0000_0200, 96'd0}, {16{8'hAA}}, 7'd3, 0);
        run_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0,
               {32'h0000_0200, 96'd0}, 128'd0, 7'd4, 1);
        run_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0400, 128'd0, 128'd0, 7'd0, 0);
        run_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 128'd0, 128'd0, 7'd0, 0);
        run_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0800, 128'd0, 128'd0, 7'd0, 0);

        // random instruction stream, small address window so stores get re-read
        for (int n = 0; n < 300; n++) begin
            int kind;
            logic v, ld, st, br;
            logic [127:0] alu;
            kind = $urandom_range(0, 3);
            v  = ($urandom_range(0, 9) != 0);
            ld = (kind == 1) || (kind == 2 && $urandom_range(0, 3) == 0);
            st = (kind == 2);
            br = (kind == 3);
            alu = rand128();
            if (kind == 1 || kind == 2) alu[127:96] = {$urandom_range(0, 31), 4'h0} ^ 32'(($urandom_range(0, 1)) << 20);
            run_op(v, ld, st, br, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom, alu, rand128(), 7'($urandom_range(0, 127)), $urandom_range(0, 3));
        end

        // address wrap and counter saturation
        force dut.stall_cnt_r = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_r;
        exp_stall = 64'hFFFF_FFFE;
        @(negedge clk);
        run_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0,
               {32'hFFFF_FFF0, 96'd0}, 128'd0, 7'd1, 2);

        // reset while an access is outstanding
        exm_valid = 1'b1; exm_is_load = 1'b1; exm_is_store = 1'b0; exm_is_branch = 1'b0;
        exm_alu_result = {32'h0000_0040, 96'd0};
        @(posedge clk); @(negedge clk);
        check_eq("mid_req", ls_req, 1'b1);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_req", ls_req, 1'b0);
        check_eq("mid_rst_stall", mem_stall, 1'b0);
        check_eq("mid_rst_wb_valid", wb_valid, 1'b0);
        drive_idle();
        @(negedge clk);
        reset = 1'b0;
        exp_stall = 0;
        ls_ack = 1'b1;
        ls_rdata = rand128() | 128'd1;
        @(posedge clk); @(negedge clk);
        ls_ack = 1'b0;
        check_eq("late_ack_wb_data", wb_data, 128'd0);
        check_eq("late_ack_req", ls_req, 1'b0);
        check_eq("late_ack_wb_valid", wb_valid, 1'b0);
        @(posedge clk); @(negedge clk);
        check_eq("no_reissue", ls_req, 1'b0);
        check_eq("post_rst_cnt", stall_cnt, exp_stall[31:0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
